// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file and its busy scoreboard.
package regfile_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int NR_DEF = 2;
  localparam int CNT_W  = 32;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by pend_set, cleared by committed writes, looked up per read port.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int NR       = NR_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_addr,
  input  logic             c0,
  input  logic [AW-1:0]    ca0,
  input  logic             c1,
  input  logic [AW-1:0]    ca1,
  input  logic [NR*AW-1:0] ra,
  output logic [NR-1:0]    rbusy
);
  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] busy;

  // Set is evaluated first so a same-cycle pend_set beats the clearing write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (pend_set && pend_addr == AW'(a) && !(ZERO_REG != 0 && a == 0))
          busy[a] <= 1'b1;
        else if ((c0 && ca0 == AW'(a)) || (c1 && ca1 == AW'(a)))
          busy[a] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rb
    logic [AW-1:0] a;
    logic          hit;
    logic          pset;
    assign a    = ra[k*AW +: AW];
    assign hit  = (c0 && ca0 == a) || (c1 && ca1 == a);
    assign pset = pend_set && pend_addr == a;
    assign rbusy[k] = (ZERO_REG != 0 && a == '0)   ? 1'b0 :
                      (BYPASS != 0 && hit && !pset) ? 1'b0 :
                      busy[a];
  end
endmodule

// File: rtl/regfile_mp.sv
// Two-write, NR-read register file with optional zero register, write bypass and commit counter.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NR       = NR_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    wa0,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd0,
  input  logic [DW-1:0]    wd1,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rbusy,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_addr,
  output logic [CNT_W-1:0] wr_cnt
);
  localparam int DEPTH = 2**AW;

  logic [DW-1:0] rf [DEPTH];
  logic          c0;
  logic          c1;

  // Port 1 wins a same-address collision, so port 0 is suppressed and counted once.
  assign c1 = we1 && !(ZERO_REG != 0 && wa1 == '0);
  assign c0 = we0 && !(ZERO_REG != 0 && wa0 == '0) && !(we1 && wa1 == wa0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      wr_cnt <= '0;
    end else begin
      if (c0) rf[wa0] <= wd0;
      if (c1) rf[wa1] <= wd1;
      wr_cnt <= wr_cnt + CNT_W'(c0) + CNT_W'(c1);
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = ra[k*AW +: AW];
    assign rd[k*DW +: DW] = (ZERO_REG != 0 && a == '0)      ? '0  :
                            (BYPASS != 0 && c1 && wa1 == a) ? wd1 :
                            (BYPASS != 0 && c0 && wa0 == a) ? wd0 :
                            rf[a];
  end

  rf_scoreboard #(
    .AW       (AW),
    .NR       (NR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .c0        (c0),
    .ca0       (wa0),
    .c1        (c1),
    .ca1       (wa1),
    .ra        (ra),
    .rbusy     (rbusy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed table, reset corner cases and random traffic vs. a model.
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              we0, we1, pend_set;
  logic [AW-1:0]     wa0, wa1, pend_addr, r0, r1;
  logic [DW-1:0]     wd0, wd1;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd, rd_nb;
  logic [NR-1:0]     rbusy, rbusy_nb;
  logic [31:0]       wr_cnt, wr_cnt_nb;

  assign ra = {r1, r0};
  always #5 clk = ~clk;

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .ra(ra), .rd(rd), .rbusy(rbusy),
    .pend_set(pend_set), .pend_addr(pend_addr), .wr_cnt(wr_cnt));

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb),
    .pend_set(pend_set), .pend_addr(pend_addr), .wr_cnt(wr_cnt_nb));

  // Reference state: architectural registers, busy flags, commit count.
  logic [31:0] m_rf [DEPTH];
  bit          m_busy [DEPTH];
  logic [31:0] m_cnt;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    bit          we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    bit          ps;
    logic [4:0]  pa, r0, r1;
    logic [31:0] e0, e1, enb0;
    logic [1:0]  eb;
    logic [31:0] ecnt;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit wr1();
    return we1 && wa1 != 0;
  endfunction
  function automatic bit wr0();
    return we0 && wa0 != 0 && !(we1 && wa1 == wa0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wr1() && wa1 == a) return wd1;
    if (byp && wr0() && wa0 == a) return wd0;
    return m_rf[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && ((wr1() && wa1 == a) || (wr0() && wa0 == a)) && !(pend_set && pend_addr == a))
      return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = '0;
  endtask

  task automatic model_edge();
    bit c0, c1;
    c0 = wr0();
    c1 = wr1();
    if (c0) begin m_rf[wa0] = wd0; m_busy[wa0] = 1'b0; m_cnt++; end
    if (c1) begin m_rf[wa1] = wd1; m_busy[wa1] = 1'b0; m_cnt++; end
    if (pend_set && pend_addr != 0) m_busy[pend_addr] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [4:0] a;
    for (int k = 0; k < NR; k++) begin
      a = ra[k*AW +: AW];
      chk($sformatf("%s rd[%0d]", tag, k), rd[k*DW +: DW], exp_rd(a, 1'b1));
      chk($sformatf("%s rd_nb[%0d]", tag, k), rd_nb[k*DW +: DW], exp_rd(a, 1'b0));
      chk($sformatf("%s rbusy[%0d]", tag, k), {31'b0, rbusy[k]}, {31'b0, exp_busy(a, 1'b1)});
      chk($sformatf("%s rbusy_nb[%0d]", tag, k), {31'b0, rbusy_nb[k]}, {31'b0, exp_busy(a, 1'b0)});
    end
    chk({tag, " wr_cnt"}, wr_cnt, m_cnt);
    chk({tag, " wr_cnt_nb"}, wr_cnt_nb, m_cnt);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    pend_set = 0; pend_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 0, 0, 0, 2'b00, 0};
    tbl[1] = '{1, 1, 5, 5, 32'h11111111, 32'h22222222, 0, 0, 5, 0,
               32'h22222222, 0, 0, 2'b00, 0};
    tbl[2] = '{1, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0, 32'h22222222, 0, 2'b00, 1};
    tbl[3] = '{1, 0, 9, 0, 32'hCAFEF00D, 0, 0, 0, 9, 5,
               32'hCAFEF00D, 32'h22222222, 0, 2'b00, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 1, 12, 12, 9, 0, 32'hCAFEF00D, 0, 2'b00, 2};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 0, 0, 0, 2'b11, 2};
    tbl[6] = '{0, 1, 0, 12, 0, 32'h12121212, 0, 0, 12, 9,
               32'h12121212, 32'hCAFEF00D, 0, 2'b00, 2};
    tbl[7] = '{1, 0, 12, 0, 32'h34343434, 0, 1, 12, 12, 12,
               32'h34343434, 32'h34343434, 32'h12121212, 2'b00, 3};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 12, 5,
               32'h34343434, 32'h22222222, 32'h34343434, 2'b01, 4};

    idle();
    r0 = 5'd3; r1 = 5'd7;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      we0 = tbl[i].we0; we1 = tbl[i].we1; wa0 = tbl[i].wa0; wa1 = tbl[i].wa1;
      wd0 = tbl[i].wd0; wd1 = tbl[i].wd1; pend_set = tbl[i].ps; pend_addr = tbl[i].pa;
      r0 = tbl[i].r0; r1 = tbl[i].r1;
      #2;
      chk($sformatf("vec%0d rd0", i), rd[31:0], tbl[i].e0);
      chk($sformatf("vec%0d rd1", i), rd[63:32], tbl[i].e1);
      chk($sformatf("vec%0d rd_nb0", i), rd_nb[31:0], tbl[i].enb0);
      chk($sformatf("vec%0d rbusy", i), {30'b0, rbusy}, {30'b0, tbl[i].eb});
      chk($sformatf("vec%0d wr_cnt", i), wr_cnt, tbl[i].ecnt);
      check_all($sformatf("vec%0d", i));
      tick();
    end

    // Reset dropped mid-cycle during back-to-back writes.
    idle();
    we0 = 1; wa0 = 5'd3; wd0 = 32'hA5A5A5A5; pend_set = 1; pend_addr = 5'd4;
    tick();
    we0 = 1; wa0 = 5'd4; wd0 = 32'h5A5A5A5A; pend_set = 1; pend_addr = 5'd3;
    tick();
    we0 = 1; wa0 = 5'd6; wd0 = 32'h66666666; pend_set = 1; pend_addr = 5'd6;
    r0 = 5'd3; r1 = 5'd4;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst rd0", rd[31:0], 32'h0);
    chk("midrst rd1", rd[63:32], 32'h0);
    chk("midrst rbusy", {30'b0, rbusy}, 32'h0);
    chk("midrst wr_cnt", wr_cnt, 32'h0);
    @(posedge clk);
    #1;
    chk("inrst wr_cnt", wr_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    r0 = 5'd6; r1 = 5'd3;
    #2;
    chk("postrst lost rd0", rd[31:0], 32'h0);
    chk("postrst rbusy", {30'b0, rbusy}, 32'h0);
    check_all("postrst");
    tick();

    for (int n = 0; n < 400; n++) begin
      we0 = ($urandom_range(0, 1) == 1);
      we1 = ($urandom_range(0, 2) == 0);
      wa0 = 5'($urandom_range(0, 15));
      wa1 = 5'($urandom_range(0, 15));
      wd0 = $urandom;
      wd1 = $urandom;
      pend_set = ($urandom_range(0, 3) == 0);
      pend_addr = 5'($urandom_range(0, 15));
      r0 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 15));
      r1 = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom_range(0, 15));
      #2;
      check_all($sformatf("rnd%0d", n));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
